// File: rtl/muldiv_pkg.sv
// Shared opcode and state types for the iterative RV32M multiply/divide unit.
// The instruction decoder imports this package to drive the unit's op input.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    localparam int          MD_ITER     = 32;
    localparam logic [31:0] MD_DIV_ONES = 32'hFFFF_FFFF;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: sign-magnitude shift-add multiply and
// restoring divide sharing one counter, fixed 33-cycle latency from start to done.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    muldiv_state_t      state;
    muldiv_state_t      state_next;
    muldiv_op_t         op_in;
    muldiv_op_t         op_q;
    logic [5:0]         cnt;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   a_q;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   rem;
    logic               neg_q;
    logic               div_zero_q;

    logic               signed_a;
    logic               signed_b;
    logic               neg_a;
    logic               neg_b;
    logic               is_div;
    logic               is_rem;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic               div_fits;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quotient;
    logic [WIDTH-1:0]   remainder;
    logic [WIDTH-1:0]   fix_result;

    assign op_in    = muldiv_op_t'(op);
    assign is_div   = op[2];
    assign is_rem   = op[2] & op[1];
    assign signed_a = op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    assign signed_b = op_in inside {OP_MULH, OP_DIV, OP_REM};
    assign neg_a    = signed_a & a[WIDTH-1];
    assign neg_b    = signed_b & b[WIDTH-1];
    assign abs_a    = neg_a ? -a : a;
    assign abs_b    = neg_b ? -b : b;
    assign busy     = (state != IDLE);

    // acc holds {product high, multiplier} for multiply and {0, dividend/quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd_q} : '0);
        div_shift = {rem, acc[WIDTH-1]};
        div_fits  = (div_shift >= {1'b0, opnd_q});
        product   = neg_q ? -acc : acc;
        quotient  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        remainder = neg_q ? -rem : rem;
    end

    // Divide-by-zero overrides; signed overflow falls out of the magnitude datapath.
    always_comb begin
        fix_result = '0;
        case (op_q)
            OP_MUL:                       fix_result = product[WIDTH-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_result = product[2*WIDTH-1:WIDTH];
            OP_DIV, OP_DIVU:              fix_result = div_zero_q ? MD_DIV_ONES : quotient;
            OP_REM, OP_REMU:              fix_result = div_zero_q ? a_q : remainder;
            default:                      fix_result = '0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == 6'(MD_ITER - 1)) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= OP_MUL;
            cnt        <= '0;
            opnd_q     <= '0;
            a_q        <= '0;
            acc        <= '0;
            rem        <= '0;
            neg_q      <= 1'b0;
            div_zero_q <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q       <= op_in;
                        neg_q      <= is_rem ? neg_a : (neg_a ^ neg_b);
                        div_zero_q <= (b == '0);
                        a_q        <= a;
                        opnd_q     <= is_div ? abs_b : abs_a;
                        acc        <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
                        rem        <= '0;
                        cnt        <= '0;
                    end
                end
                CALC: begin
                    cnt <= cnt + 6'd1;
                    if (op_q[2]) begin
                        acc[WIDTH-1:0] <= {acc[WIDTH-2:0], div_fits};
                        rem            <= div_fits ? (div_shift[WIDTH-1:0] - opnd_q)
                                                   : div_shift[WIDTH-1:0];
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    result <= fix_result;
                    done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, latency and busy
// checks on every completion, ignored/back-to-back starts and reset abort.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks   = 0;
    int errors   = 0;
    int cyc      = 0;
    int busy_run = 0;
    int tag_next = 0;

    logic [31:0] exp_q[$];
    int          cyc_q[$];
    int          tag_q[$];

    logic [31:0] mon_exp;
    int          mon_cyc;
    int          mon_tag;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the oldest expectation on every done and checks value, latency and busy span.
    always @(negedge clk) begin
        if (rst) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_done got result=%h expected=no done", result);
                end else begin
                    mon_exp = exp_q.pop_front();
                    mon_cyc = cyc_q.pop_front();
                    mon_tag = tag_q.pop_front();
                    check_output($sformatf("vec%0d_result", mon_tag), result, mon_exp);
                    check_output($sformatf("vec%0d_latency", mon_tag), 32'(cyc - mon_cyc), 32'd33);
                    check_output($sformatf("vec%0d_busy_span", mon_tag), 32'(busy_run), 32'd33);
                    check_output($sformatf("vec%0d_busy_in_done", mon_tag), {31'b0, busy}, 32'd0);
                end
                busy_run = 0;
            end
        end
    end

    // Called on a falling edge; start is sampled on the following rising edge.
    task automatic drive(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] ex, input bit push);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        if (push) begin
            exp_q.push_back(ex);
            cyc_q.push_back(cyc + 1);
            tag_q.push_back(tag_next);
        end
        tag_next++;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic apply_stimulus(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                  input logic [31:0] ex, input bit push);
        @(negedge clk);
        drive(o, va, vb, ex, push);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while ((busy || exp_q.size() != 0) && n < budget);
        if (busy || exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_timeout got busy=%0b pending=%0d expected=idle", busy, exp_q.size());
        end
    endtask

    task automatic run_vec(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] ex);
        wait_idle(60);
        apply_stimulus(o, va, vb, ex, 1'b1);
    endtask

    task automatic start_in_done_cycle(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                                       input logic [31:0] ex);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 60);
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_wait_timeout got done=0 expected=1");
        end else begin
            drive(o, va, vb, ex, 1'b1);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check_output("reset_busy",   {31'b0, busy}, 32'd0);
        check_output("reset_done",   {31'b0, done}, 32'd0);
        check_output("reset_result", result,        32'd0);
        rst = 1'b0;

        run_vec(OP_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_vec(OP_MUL,    32'hFFFF_FFFD,  32'hFFFF_FFFD, 32'd9);
        run_vec(OP_MUL,    32'h0001_0000,  32'h0001_0000, 32'd0);
        run_vec(OP_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_vec(OP_MULHU,  32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
        run_vec(OP_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_vec(OP_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0);
        run_vec(OP_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_vec(OP_DIV,    32'h1234_5678,  32'd0,         32'hFFFF_FFFF);
        run_vec(OP_REMU,   32'h1234_5678,  32'd0,         32'h1234_5678);
        run_vec(OP_DIV,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFFF);
        run_vec(OP_REM,    32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);
        run_vec(OP_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_vec(OP_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0);
        run_vec(OP_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_vec(OP_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_vec(OP_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_vec(OP_REM,    32'd7,          32'hFFFF_FFFE, 32'd1);

        // A start during the busy window must be dropped; one in the done cycle must be taken.
        run_vec(OP_REMU, 32'd100, 32'd7, 32'd2);
        repeat (9) @(negedge clk);
        drive(OP_MUL, 32'd3, 32'd3, 32'd9, 1'b0);
        start_in_done_cycle(OP_DIVU, 32'd100, 32'd7, 32'd14);
        wait_idle(60);
        repeat (40) @(negedge clk);

        // Abort a divide mid-flight; no completion may follow.
        @(negedge clk);
        drive(OP_DIV, 32'd1000, 32'd3, 32'd0, 1'b0);
        repeat (14) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check_output("abort_busy",   {31'b0, busy}, 32'd0);
        check_output("abort_done",   {31'b0, done}, 32'd0);
        check_output("abort_result", result,        32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_output("abort_idle_busy", {31'b0, busy}, 32'd0);

        run_vec(OP_DIVU, 32'd1000, 32'd3, 32'd333);
        wait_idle(60);
        check_output("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
